// File: rtl/cm_dcnt.sv
// Down-counting loop index: walks upper-1..0, reloads on wrap, counts passes
// and parks in DONE after the programmed number of passes (0 = endless).
module cm_dcnt #(
   parameter int unsigned C_WIDTH = 8,
   parameter int unsigned P_WIDTH = 8
) (
   input  logic               I_clk,
   input  logic               I_rst_n,
   input  logic               I_cnt_en,
   input  logic               I_cnt_valid,
   input  logic [C_WIDTH-1:0] I_cnt_upper,
   input  logic [P_WIDTH-1:0] I_pass_num,
   output logic [C_WIDTH-1:0] O_cnt,
   output logic               O_last_flag,
   output logic               O_wrap,
   output logic [P_WIDTH-1:0] O_pass_cnt,
   output logic               O_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t             state_q, state_d;
   logic [C_WIDTH-1:0] cnt_q, cnt_d;
   logic [C_WIDTH-1:0] reload_q, reload_d;
   logic [P_WIDTH-1:0] target_q, target_d;
   logic [P_WIDTH-1:0] pass_q, pass_d;
   logic               last_q, last_d;
   logic               wrap_q, wrap_d;

   logic [C_WIDTH-1:0] upper_m1;
   logic [P_WIDTH-1:0] pass_inc;
   logic               wrap_ev;
   logic               hit;

   always_comb begin
      // upper of 0 saturates to a single-entry loop
      upper_m1 = (I_cnt_upper == '0) ? '0 : I_cnt_upper - C_WIDTH'(1);
      pass_inc = pass_q + P_WIDTH'(1);
      wrap_ev  = (state_q == ST_RUN) && I_cnt_valid && (cnt_q == '0);
      hit      = (target_q != '0) && (pass_inc == target_q);
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         target_q <= '0;
         pass_q   <= '0;
         last_q   <= 1'b0;
         wrap_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         target_q <= target_d;
         pass_q   <= pass_d;
         last_q   <= last_d;
         wrap_q   <= wrap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!I_cnt_en) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  if (wrap_ev && hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      reload_d = reload_q;
      target_d = target_q;
      pass_d   = pass_q;
      last_d   = last_q;
      wrap_d   = 1'b0;
      if (!I_cnt_en || state_q == ST_IDLE) begin
         cnt_d    = upper_m1;
         reload_d = upper_m1;
         target_d = I_pass_num;
         pass_d   = '0;
         last_d   = I_cnt_en && (upper_m1 == '0);
      end else if (state_q == ST_RUN && I_cnt_valid) begin
         if (cnt_q != '0) begin
            cnt_d  = cnt_q - C_WIDTH'(1);
            last_d = (cnt_q == C_WIDTH'(1));
         end else begin
            pass_d = pass_inc;
            // the terminal wrap enters DONE without a wrap pulse
            if (hit) begin
               cnt_d  = '0;
               last_d = 1'b0;
            end else begin
               cnt_d  = reload_q;
               last_d = (reload_q == '0);
               wrap_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      O_cnt       = cnt_q;
      O_last_flag = last_q;
      O_wrap      = wrap_q;
      O_pass_cnt  = pass_q;
      O_done      = (state_q == ST_DONE);
   end

endmodule

// File: tb/tb_cm_dcnt.sv
// Bench for cm_dcnt: directed scenarios plus random traffic, both checked
// against an index/pass model; a second instance uses a 2-bit pass counter.
module tb_cm_dcnt;

   logic       I_clk;
   logic       I_rst_n;
   logic       en, valid;
   logic [7:0] upper, pn;

   logic [7:0] cnt0, pass0;
   logic       last0, wrap0, done0;
   logic [7:0] cnt1;
   logic [1:0] pass1;
   logic       last1, wrap1, done1;

   int n_tests = 0;
   int n_fail  = 0;

   cm_dcnt #(.C_WIDTH(8), .P_WIDTH(8)) u0 (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_cnt_en(en), .I_cnt_valid(valid),
      .I_cnt_upper(upper), .I_pass_num(pn), .O_cnt(cnt0), .O_last_flag(last0),
      .O_wrap(wrap0), .O_pass_cnt(pass0), .O_done(done0));

   cm_dcnt #(.C_WIDTH(8), .P_WIDTH(2)) u1 (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_cnt_en(en), .I_cnt_valid(valid),
      .I_cnt_upper(upper), .I_pass_num(pn[1:0]), .O_cnt(cnt1), .O_last_flag(last1),
      .O_wrap(wrap1), .O_pass_cnt(pass1), .O_done(done1));

   logic [18:0] dv0, dv1;
   assign dv0 = {cnt0, last0, wrap0, pass0, done0};
   assign dv1 = {cnt1, last1, wrap1, 6'b0, pass1, done1};

   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   // Model: loop index, pass count, and whether the loop is running or finished.
   int unsigned m_cnt[2], m_reload[2], m_target[2], m_pass[2];
   bit          m_run[2], m_done[2], m_wrap[2];
   int unsigned pmod[2] = '{256, 4};

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_reload[k] = 0; m_target[k] = 0; m_pass[k] = 0;
         m_run[k] = 0; m_done[k] = 0; m_wrap[k] = 0;
      end
   endtask

   task automatic model_step();
      int unsigned top;
      top = (upper == 0) ? 0 : int'(upper) - 1;
      for (int k = 0; k < 2; k++) begin
         m_wrap[k] = 0;
         if (!en || (!m_run[k] && !m_done[k])) begin
            m_run[k]    = en;
            m_done[k]   = 0;
            m_cnt[k]    = top;
            m_reload[k] = top;
            m_target[k] = int'(pn) % pmod[k];
            m_pass[k]   = 0;
         end else if (m_run[k] && valid) begin
            if (m_cnt[k] > 0) begin
               m_cnt[k]--;
            end else begin
               m_pass[k] = (m_pass[k] + 1) % pmod[k];
               if (m_target[k] != 0 && m_pass[k] == m_target[k]) begin
                  m_run[k]  = 0;
                  m_done[k] = 1;
               end else begin
                  m_cnt[k]  = m_reload[k];
                  m_wrap[k] = 1;
               end
            end
         end
      end
   endtask

   function automatic logic [18:0] exp_vec(int k);
      logic [7:0] c, p;
      c = 8'(m_cnt[k]);
      p = 8'(m_pass[k]);
      return {c, (m_run[k] && m_cnt[k] == 0), m_wrap[k], p, m_done[k]};
   endfunction

   task automatic tick();
      @(posedge I_clk);
      model_step();
      @(negedge I_clk);
   endtask

   task automatic test_reset();
      I_rst_n = 1'b0; en = 0; valid = 0; upper = 8'd4; pn = 8'd2;
      model_reset();
      #3;
      if (dv0 !== '0) begin n_fail++; $display("FAIL reset_u0 got %h want 0", dv0); end
      n_tests++;
      if (dv1 !== '0) begin n_fail++; $display("FAIL reset_u1 got %h want 0", dv1); end
      n_tests++;
      @(negedge I_clk);
      I_rst_n = 1'b1;
   endtask

   task automatic test_back_to_back();
      int tab[9] = '{3, 3, 2, 1, 0, 3, 2, 1, 0};
      upper = 8'd4; pn = 8'd2; en = 0; valid = 0;
      tick();
      for (int i = 0; i < 10; i++) begin
         if (dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL b2b_model c%0d got %h want %h", i, dv0, exp_vec(0)); end
         n_tests++;
         if (i < 9) begin
            if (cnt0 !== 8'(tab[i])) begin n_fail++; $display("FAIL b2b_cnt c%0d got %0d want %0d", i, cnt0, tab[i]); end
            n_tests++;
            if (last0 !== 1'(i >= 1 && tab[i] == 0)) begin n_fail++; $display("FAIL b2b_last c%0d got %b", i, last0); end
            n_tests++;
            if (wrap0 !== 1'(i == 5)) begin n_fail++; $display("FAIL b2b_wrap c%0d got %b", i, wrap0); end
            n_tests++;
         end else begin
            if (done0 !== 1'b1 || pass0 !== 8'd2) begin n_fail++; $display("FAIL b2b_done got done=%b pass=%0d want 1/2", done0, pass0); end
            n_tests++;
         end
         en = 1; valid = (i >= 1);
         tick();
      end
   endtask

   task automatic test_valid_gaps();
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int tab[7] = '{3, 2, 2, 2, 1, 0, 0};
      en = 0; valid = 0; upper = 8'd4; pn = 8'd1;
      tick();
      en = 1;
      tick();
      for (int i = 0; i < 7; i++) begin
         if (cnt0 !== 8'(tab[i]) || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL gaps_cnt c%0d got %h want cnt %0d", i, dv0, tab[i]); end
         n_tests++;
         valid = pat[i][0];
         tick();
      end
      if (done0 !== 1'b1 || cnt0 !== 8'd0 || pass0 !== 8'd1) begin n_fail++; $display("FAIL gaps_done got %h want done", dv0); end
      n_tests++;
   endtask

   task automatic test_small_upper();
      int ups[2] = '{1, 0};
      for (int u = 0; u < 2; u++) begin
         en = 0; valid = 0; upper = 8'(ups[u]); pn = 8'd3;
         tick();
         en = 1;
         tick();
         valid = 1;
         for (int i = 0; i < 4; i++) begin
            if (dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL small_model u%0d c%0d got %h want %h", ups[u], i, dv0, exp_vec(0)); end
            n_tests++;
            if (cnt0 !== 8'd0 || last0 !== 1'(i < 3) || wrap0 !== 1'(i == 1 || i == 2) || done0 !== 1'(i == 3)) begin
               n_fail++; $display("FAIL small_flags u%0d c%0d got cnt=%0d last=%b wrap=%b done=%b", ups[u], i, cnt0, last0, wrap0, done0);
            end
            n_tests++;
            tick();
         end
      end
   endtask

   task automatic test_pass_wrap();
      en = 0; valid = 0; upper = 8'd2; pn = 8'd0;
      tick();
      en = 1;
      tick();
      valid = 1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (dv1 !== exp_vec(1) || done1 !== 1'b0) begin n_fail++; $display("FAIL pwrap_u1 c%0d got %h want %h", i, dv1, exp_vec(1)); end
         n_tests++;
      end
      if (pass1 !== 2'd2) begin n_fail++; $display("FAIL pwrap_final got %0d want 2", pass1); end
      n_tests++;
   endtask

   task automatic test_en_drop();
      bit found = 0;
      en = 0; valid = 0; upper = 8'd4; pn = 8'd0;
      tick();
      en = 1; valid = 1;
      tick();
      for (int i = 0; i < 20 && !found; i++) begin
         if (cnt0 == 8'd1 && pass0 != 8'd0) found = 1;
         else tick();
      end
      if (!found) begin n_fail++; $display("FAIL endrop_wait got cnt=%0d pass=%0d want cnt 1 after a wrap", cnt0, pass0); end
      n_tests++;
      en = 0; upper = 8'd6;
      tick();
      if (dv0 !== {8'd5, 1'b0, 1'b0, 8'd0, 1'b0} || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL endrop_idle got %h want cnt 5 rest 0", dv0); end
      n_tests++;
      en = 1;
      tick();
      if (cnt0 !== 8'd5 || pass0 !== 8'd0 || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL endrop_run got %h want cnt 5 pass 0", dv0); end
      n_tests++;
      tick();
      if (cnt0 !== 8'd4 || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL endrop_dec got %0d want 4", cnt0); end
      n_tests++;
   endtask

   task automatic test_async_reset();
      en = 0; valid = 0; upper = 8'd5; pn = 8'd0;
      tick();
      en = 1; valid = 1;
      tick(); tick(); tick();
      if (cnt0 !== 8'd2 || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL arst_pre got %0d want 2", cnt0); end
      n_tests++;
      #2 I_rst_n = 1'b0;
      #1;
      model_reset();
      if (dv0 !== '0 || dv1 !== '0) begin n_fail++; $display("FAIL arst_zero got %h / %h want 0", dv0, dv1); end
      n_tests++;
      #1 I_rst_n = 1'b1;
      tick();
      if (cnt0 !== 8'd4 || pass0 !== 8'd0 || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL arst_reload got %h want cnt 4", dv0); end
      n_tests++;
      tick();
      if (cnt0 !== 8'd3 || dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL arst_run got %0d want 3", cnt0); end
      n_tests++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en    = ($urandom % 16) != 0;
         valid = ($urandom % 3) != 0;
         if ($urandom % 8 == 0) upper = 8'($urandom_range(0, 6));
         if ($urandom % 8 == 0) pn    = 8'($urandom_range(0, 5));
         tick();
         if (dv0 !== exp_vec(0)) begin n_fail++; $display("FAIL rand_u0 c%0d got %h want %h", i, dv0, exp_vec(0)); end
         n_tests++;
         if (dv1 !== exp_vec(1)) begin n_fail++; $display("FAIL rand_u1 c%0d got %h want %h", i, dv1, exp_vec(1)); end
         n_tests++;
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_valid_gaps();
      test_small_upper();
      test_pass_wrap();
      test_en_drop();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
